// File: rtl/crc16_fault.sv
// CRC-16 engine (no reflection, no final XOR) folding one 16-bit word per enabled cycle.
// Optional stuck-at fault injector on the input word, enabled by `define CRC16_FAULT_INJECT_EN.
module crc16_fault #(
    parameter logic [15:0] POLY = 16'h1021,
    parameter logic [15:0] INIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] data_in,
    input  logic [15:0] fault_mask,
    input  logic [15:0] fault_value,
    output logic [15:0] crc_out
);

    logic [15:0] r_crc;
    logic [15:0] w_eff;
    logic [15:0] w_crcNext;
    logic        w_fb;

`ifdef CRC16_FAULT_INJECT_EN
    // Masked bits take the stuck value; unmasked fault_value bits never reach the datapath.
    assign w_eff = (data_in & ~fault_mask) | (fault_value & fault_mask);
`else
    wire w_unusedFault = ^{fault_mask, fault_value};
    assign w_eff = data_in;
`endif

    // Sixteen serial CRC steps unrolled into one combinational network, MSB first.
    always_comb begin
        w_crcNext = r_crc;
        w_fb      = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            w_fb      = w_crcNext[15] ^ w_eff[i];
            w_crcNext = {w_crcNext[14:0], 1'b0} ^ (w_fb ? POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_crc <= INIT;
        end else if (enable) begin
            r_crc <= w_crcNext;
        end
    end

    assign crc_out = r_crc;

endmodule

// File: tb/tb_crc16_fault.sv
// Scoreboard bench for crc16_fault: driver pushes expected CRC, monitor pops and compares.
// Reference model uses polynomial long division; honours CRC16_FAULT_INJECT_EN like the DUT.
module tb_crc16_fault;

    localparam logic [15:0] POLY = 16'h1021;
    localparam logic [15:0] INIT = 16'hFFFF;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] data_in;
    logic [15:0] fault_mask;
    logic [15:0] fault_value;
    logic [15:0] crc_out;

    int compared;
    int mismatched;
    logic [15:0] modelCrc;
    logic [15:0] expQ[$];

    crc16_fault #(.POLY(POLY), .INIT(INIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .data_in    (data_in),
        .fault_mask (fault_mask),
        .fault_value(fault_value),
        .crc_out    (crc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // (crc ^ word) * x^16 mod P, by long division of a 32-bit dividend.
    function automatic logic [15:0] crcWord(input logic [15:0] crc, input logic [15:0] word);
        logic [31:0] r;
        logic [31:0] divisor;
        r = {crc ^ word, 16'h0000};
        for (int i = 31; i >= 16; i--) begin
            if (r[i]) begin
                divisor = {15'h0000, 1'b1, POLY} << (i - 16);
                r = r ^ divisor;
            end
        end
        return r[15:0];
    endfunction

    function automatic logic [15:0] effWord(input logic [15:0] d, input logic [15:0] m,
                                            input logic [15:0] v);
`ifdef CRC16_FAULT_INJECT_EN
        logic [15:0] e;
        e = d;
        for (int b = 0; b < 16; b++) begin
            if (m[b]) e[b] = v[b];
        end
        return e;
`else
        return d;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: crc_out=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle at negedge; expected value comes from the model unless a constant is given.
    task automatic applyStimulus(input logic en, input logic [15:0] d, input logic [15:0] m,
                                 input logic [15:0] v, input logic useConst,
                                 input logic [15:0] constExp);
        logic [15:0] nxt;
        @(negedge clk);
        enable      = en;
        data_in     = d;
        fault_mask  = m;
        fault_value = v;
        nxt = en ? crcWord(modelCrc, effWord(d, m, v)) : modelCrc;
        modelCrc = nxt;
        expQ.push_back(useConst ? constExp : nxt);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        #2;
        checkOutput("reset_hold", crc_out, INIT);
        @(negedge clk);
        reset    = 1'b0;
        modelCrc = INIT;
    endtask

    always @(posedge clk) begin
        logic [15:0] e;
        #2;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("scoreboard", crc_out, e);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] expA;
        compared    = 0;
        mismatched  = 0;
        modelCrc    = INIT;
        reset       = 1'b1;
        enable      = 1'b0;
        data_in     = 16'h0000;
        fault_mask  = 16'h0000;
        fault_value = 16'h0000;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_init", crc_out, INIT);
        @(negedge clk);
        reset = 1'b0;

        // Zero result, then x^16 mod P
        applyStimulus(1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 16'h0000);
        applyStimulus(1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b1, 16'h1021);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 16'h1021);
        end

        // Stuck-at-0 on bit 0 and bit 1
        doReset();
`ifdef CRC16_FAULT_INJECT_EN
        expA = 16'h1021;
`else
        expA = 16'h0000;
`endif
        applyStimulus(1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, expA);
        doReset();
`ifdef CRC16_FAULT_INJECT_EN
        expA = 16'h2042;
`else
        expA = 16'h0000;
`endif
        applyStimulus(1'b1, 16'hFFFF, 16'h0002, 16'h0000, 1'b1, expA);

        // Stuck-at-1 on every bit
        doReset();
`ifdef CRC16_FAULT_INJECT_EN
        applyStimulus(1'b1, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000);
`else
        applyStimulus(1'b1, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000);
`endif

        // fault_value outside the mask has no effect
        doReset();
        applyStimulus(1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, 16'h0000);

        // Asynchronous reset in the middle of a cycle after some updates
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 16'h0000);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", crc_out, INIT);
        @(negedge clk);
        reset    = 1'b0;
        modelCrc = INIT;
        enable   = 1'b0;

        // Randomized traffic with sparse masks and random enable
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 16'($urandom),
                          16'($urandom) & 16'($urandom), 16'($urandom), 1'b0, 16'h0000);
        end

        @(negedge clk);
        enable = 1'b0;
        for (int w = 0; w < 10 && expQ.size() > 0; w++) @(posedge clk);
        #3;
        if (expQ.size() > 0) begin
            mismatched++;
            compared++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/crc16_fault.md
Name: crc16_fault

Overview:
- 16-bit-per-cycle CRC-16 engine with an input-side stuck-at fault injector, for fault-model experiments on the CRC datapath.
- Each enabled cycle takes one 16-bit word, forces selected bits to stuck values, and folds the result into the running CRC register.
- Sits between a stimulus/fault-campaign controller and any logger or monitor that samples crc_out.

Parameters:
- POLY, 16'h1021, generator polynomial (implicit x^16 term); default is CRC-16/CCITT.
- INIT, 16'hFFFF, CRC register value on reset.

Ports:
- clk  input  1  rising-edge clock; the block's single clock domain.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  process data_in this cycle.
- data_in  input  16  data word, MSB processed first.
- fault_mask  input  16  1 = corresponding data bit is faulted.
- fault_value  input  16  stuck value applied to masked bits.
- crc_out  output  16  current CRC register, driven directly from a flop.

Behaviour:
- Reset: asynchronous on reset=1; crc_out = INIT (0xFFFF) immediately and while held; first update at the first rising clk edge with reset=0 and enable=1.
- Fault injection, combinational: eff = (data_in & ~fault_mask) | (fault_value & fault_mask).
  - mask=0 passes the bit through.
  - mask=1 forces bit = fault_value bit, giving stuck-at-0 or stuck-at-1 per bit.
  - fault_value bits where mask=0 are ignored.
- Update on posedge clk when enable=1: crc_next = 16 serial steps, MSB first, over eff[15]..eff[0].
  - Per step: fb = crc[15] ^ d; crc = {crc[14:0],1'b0} ^ (fb ? POLY : 0).
  - Equivalently, crc_next = F(crc ^ eff), where F(x) = x·x^16 mod P.
  - Implement as a single-cycle unrolled combinational network; no multi-cycle state machine.
- Format: no input/output reflection, no final XOR.
- Latency: crc_out reflects a word one clock after the enabled edge that captures it.
- enable=0: crc_out holds; data_in, fault_mask and fault_value are don't-care.
- Back-to-back enables: one word per cycle, no stall, no handshake.
- Reset mid-stream: accumulated state is discarded and crc_out returns to INIT asynchronously.
- Fault inputs are sampled only at enabled edges; they may change every cycle.
- No X propagation from fault_value bits where mask=0.

Optional Feature:
- Macro: CRC16_FAULT_INJECT_EN.
- Defined: injector active as described above.
- Undefined:
  - eff = data_in; fault_mask and fault_value ignored (ports remain, unused).
  - Same CRC result as defining the macro and driving fault_mask=0.

Test Plan:
- Reset: assert reset, then release → crc_out=0xFFFF; assert reset asynchronously mid-cycle after updates → crc_out=0xFFFF before the next edge.
- No fault, zero result: from INIT, enable with data 0xFFFF, mask 0x0000 → crc_out=0x0000; next word 0x0001 → crc_out=0x1021.
- Stuck-at-0: from INIT, data 0xFFFF, mask 0x0001, value 0x0000 (eff 0xFFFE) → crc_out=0x1021; repeat with mask 0x0002 (eff 0xFFFD) → 0x2042.
- Stuck-at-1, all bits: from INIT, data 0x0000, mask 0xFFFF, value 0xFFFF (eff 0xFFFF) → crc_out=0x0000; value bits outside mask ignored (mask 0x0000, value 0xFFFF, data 0xFFFF → 0x0000).
- Hold: after reaching 0x1021, hold enable=0 for 5 cycles while toggling data and mask → crc_out stays 0x1021.
- Macro undefined: from INIT, data 0xFFFF, mask 0x0001, value 0x0000 → crc_out=0x0000 (fault ignored).
